multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control FSM that sequences a shared multi-cycle MIPS datapath. The datapath has a single ALU, a single unified memory port, the register file, IR, ALUOut/MDR and PC. The FSM takes the opcode from IR and the ALU zero flag, and drives every datapath select and write strobe. It performs a request/acknowledge handshake with a variable-latency memory and counts retired instructions.

Parameters:
ACK_TIMEOUT, 255, max cycles mem_req_o may stay high without mem_ack_i; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  run enable; sampled at instruction boundaries
op_i  in  6  IR[31:26]
zero_i  in  1  ALU zero flag
mem_ack_i  in  1  memory access complete (read data valid / write accepted)
mem_req_o  out  1  memory request
mem_we_o  out  1  write qualifier for mem_req_o
iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write_o  out  1  load IR
pc_write_o  out  1  load PC
pc_src_o  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
alu_src_a_o  out  1  ALU A: 0 = PC, 1 = rs data
alu_src_b_o  out  2  ALU B: 0 = rt data, 1 = 4, 2 = sext(imm), 3 = sext(imm)<<2
alu_op_o  out  2  ALU op: 00 = add, 01 = sub, 10 = decode funct
reg_write_o  out  1  register file write
reg_dst_o  out  1  write address: 0 = rt, 1 = rd
mem_to_reg_o  out  1  write data: 0 = ALUOut, 1 = MDR
busy_o  out  1  high in every state except IDLE and ERR
err_o  out  1  high in ERR
state_o  out  4  current state encoding (debug)
inst_cnt_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_i=0, asynchronous): state = IDLE, inst_cnt_o = 0, wait counter = 0.
- While in reset, every output is 0.
- Any output not listed for a state is 0.
- Reset asserted mid-instruction aborts it immediately; no strobe is emitted after the reset edge.
- State encodings (IDLE=0 … ERR=12):
  - IDLE: go to FETCH when start_i=1.
  - FETCH: mem_req, iord=0, a=0, b=1, op=00.
    - On mem_ack_i (same cycle, Mealy): ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
    - Otherwise stay in FETCH.
  - DECODE: a=0, b=3, op=00 (branch target into ALUOut). Next state by op_i:
    - 000000 → EXEC_R
    - 001000 (addi) → EXEC_I
    - 100011 (lw) / 101011 (sw) → ADDR
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - any other opcode → ERR
  - ADDR: a=1, b=2, op=00. lw → MEM_RD; sw → MEM_WR.
  - MEM_RD: mem_req, iord=1. On ack → WB_MEM.
  - MEM_WR: mem_req, mem_we, iord=1. On ack → retire.
  - WB_MEM: reg_write, reg_dst=0, mem_to_reg=1 → retire.
  - EXEC_R: a=1, b=0, op=10 → WB_R.
  - WB_R: reg_write, reg_dst=1 → retire.
  - EXEC_I: a=1, b=2, op=00 → WB_I.
  - WB_I: reg_write, reg_dst=0 → retire.
  - BRANCH: a=1, b=0, op=01, pc_src=1, pc_write = zero_i (Mealy) → retire.
  - JUMP: pc_write=1, pc_src=2 → retire.
  - ERR: err_o=1. Terminal until reset; start_i is ignored.
- Retire:
  - inst_cnt_o increments by 1 on the transition edge; wraps modulo 2^CNT_W.
  - Next state is FETCH if start_i=1 in that cycle, else IDLE.
  - Dropping start_i mid-instruction never truncates the instruction.
- Timeout:
  - The wait counter clears on entry to FETCH, MEM_RD and MEM_WR.
  - It increments each cycle the FSM stays in one of these states without ack.
  - If ACK_TIMEOUT>0, ack is absent, and wait count = ACK_TIMEOUT-1, the next state is ERR. mem_req_o is therefore high for exactly ACK_TIMEOUT cycles.
  - Ack in that same cycle wins over the timeout.
- Minimum CPI (ack in the first request cycle): R/addi 4, lw 5, sw 4, beq 3, j 3.

Decomposition:
- Package multicycle_pkg: state enum, opcode constants, and the pc_src, alu_src_b and alu_op encodings.
- Sub-module mc_wait_timer: wait counter, clear/enable inputs, expired output, parameter ACK_TIMEOUT.

Test Plan:
- Reset release, start_i=1, op=000000, ack 2 cycles after request → FETCH 3 cycles, DECODE, EXEC_R, WB_R (reg_write_o=1, reg_dst_o=1 for exactly 1 cycle), inst_cnt_o=1.
- lw with ack in the first cycle of FETCH and of MEM_RD → 5-cycle instruction; iord_o=1 only in MEM_RD; WB_MEM asserts mem_to_reg_o=1.
- beq with zero_i=1, then beq with zero_i=0 → pc_write_o pulses once with pc_src_o=1 in the first case, stays 0 in the second; inst_cnt_o advances by 2.
- op_i=6'b111111 at DECODE → ERR next cycle, err_o=1, busy_o=0, no reg_write/mem_req; start_i toggling has no effect until rst_i=0.
- ACK_TIMEOUT=4, mem_ack_i held 0 → mem_req_o high exactly 4 cycles, then ERR. Ack arriving in the 4th cycle instead → normal progress.
- sw with start_i dropped in ADDR → MEM_WR completes, inst_cnt_o increments, FSM returns to IDLE. Separately, rst_i=0 pulsed in MEM_WR → all outputs 0 immediately, state IDLE, inst_cnt_o=0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM and its helpers.
package multicycle_pkg;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StAddr   = 4'd3,
        StMemRd  = 4'd4,
        StMemWr  = 4'd5,
        StWbMem  = 4'd6,
        StExecR  = 4'd7,
        StWbR    = 4'd8,
        StExecI  = 4'd9,
        StWbI    = 4'd10,
        StBranch = 4'd11,
        StErr    = 4'd12,
        StJump   = 4'd13
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    localparam logic [1:0] SrcBRt    = 2'd0;
    localparam logic [1:0] SrcBFour  = 2'd1;
    localparam logic [1:0] SrcBImm   = 2'd2;
    localparam logic [1:0] SrcBImmSh = 2'd3;

    localparam logic [1:0] AluAdd   = 2'd0;
    localparam logic [1:0] AluSub   = 2'd1;
    localparam logic [1:0] AluFunct = 2'd2;

    // States in which the FSM waits on the memory handshake.
    function automatic logic is_wait_state(input state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles spent waiting for a memory acknowledge; flags the last allowed cycle.
module mc_wait_timer #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ACK_TIMEOUT - 1);
    localparam bit Enabled = (ACK_TIMEOUT != 0);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = Enabled && (cnt_q == LastCnt);

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM sequencing a shared multi-cycle MIPS datapath with a handshaked memory port.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       op_i,
    input  logic             zero_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] inst_cnt_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             expired;

    mc_wait_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_wait_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_d != state_q),
        .en_i     (is_wait_state(state_q) && !mem_ack_i),
        .expired_o(expired)
    );

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = PcSrcAlu;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SrcBRt;
        alu_op_o     = AluAdd;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        case (state_q)
            StIdle: if (start_i) state_d = StFetch;
            StFetch: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SrcBFour;
                if (mem_ack_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = StDecode;
                end else if (expired) begin
                    state_d = StErr;
                end
            end
            StDecode: begin
                alu_src_b_o = SrcBImmSh;
                case (op_i)
                    OpRType:     state_d = StExecR;
                    OpAddi:      state_d = StExecI;
                    OpLw, OpSw:  state_d = StAddr;
                    OpBeq:       state_d = StBranch;
                    OpJ:         state_d = StJump;
                    default:     state_d = StErr;
                endcase
            end
            StAddr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SrcBImm;
                state_d     = (op_i == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                if (mem_ack_i)    state_d = StWbMem;
                else if (expired) state_d = StErr;
            end
            StMemWr: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
                if (mem_ack_i)    retire  = 1'b1;
                else if (expired) state_d = StErr;
            end
            StWbMem: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                retire       = 1'b1;
            end
            StExecR: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = AluFunct;
                state_d     = StWbR;
            end
            StWbR: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                retire      = 1'b1;
            end
            StExecI: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SrcBImm;
                state_d     = StWbI;
            end
            StWbI: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
            end
            StBranch: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = AluSub;
                pc_src_o    = PcSrcAluOut;
                pc_write_o  = zero_i;
                retire      = 1'b1;
            end
            StJump: begin
                pc_write_o = 1'b1;
                pc_src_o   = PcSrcJump;
                retire     = 1'b1;
            end
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
        // Retirement always completes the instruction; start_i only picks what follows.
        if (retire) state_d = start_i ? StFetch : StIdle;
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o     = (state_q != StIdle) && (state_q != StErr);
    assign err_o      = (state_q == StErr);
    assign state_o    = state_q;
    assign inst_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle bench for multicycle_ctrl with a queued expected-output scoreboard.
module tb_multicycle_ctrl;

    localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111;

    // {req, we, iord, irw, pcw, pcsrc[2], a, b[2], op[2], rw, rdst, m2r, busy, err}
    localparam logic [16:0] O_IDLE    = 17'b0;
    localparam logic [16:0] O_FETCH   = 17'b1_0_0_0_0_00_0_01_00_0_0_0_1_0;
    localparam logic [16:0] O_FETCHAK = 17'b1_0_0_1_1_00_0_01_00_0_0_0_1_0;
    localparam logic [16:0] O_DECODE  = 17'b0_0_0_0_0_00_0_11_00_0_0_0_1_0;
    localparam logic [16:0] O_ADDR    = 17'b0_0_0_0_0_00_1_10_00_0_0_0_1_0;
    localparam logic [16:0] O_MEMRD   = 17'b1_0_1_0_0_00_0_00_00_0_0_0_1_0;
    localparam logic [16:0] O_MEMWR   = 17'b1_1_1_0_0_00_0_00_00_0_0_0_1_0;
    localparam logic [16:0] O_WBMEM   = 17'b0_0_0_0_0_00_0_00_00_1_0_1_1_0;
    localparam logic [16:0] O_EXECR   = 17'b0_0_0_0_0_00_1_00_10_0_0_0_1_0;
    localparam logic [16:0] O_WBR     = 17'b0_0_0_0_0_00_0_00_00_1_1_0_1_0;
    localparam logic [16:0] O_EXECI   = 17'b0_0_0_0_0_00_1_10_00_0_0_0_1_0;
    localparam logic [16:0] O_WBI     = 17'b0_0_0_0_0_00_0_00_00_1_0_0_1_0;
    localparam logic [16:0] O_BRT     = 17'b0_0_0_0_1_01_1_00_01_0_0_0_1_0;
    localparam logic [16:0] O_BRN     = 17'b0_0_0_0_0_01_1_00_01_0_0_0_1_0;
    localparam logic [16:0] O_JUMP    = 17'b0_0_0_0_1_10_0_00_00_0_0_0_1_0;
    localparam logic [16:0] O_ERR     = 17'b0_0_0_0_0_00_0_00_00_0_0_0_0_1;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i, start_i, zero_i, mem_ack_i;
    logic [5:0]  op_i;
    logic        mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0]  pc_src_o, alu_src_b_o, alu_op_o;
    logic        alu_src_a_o, reg_write_o, reg_dst_o, mem_to_reg_o, busy_o, err_o;
    logic [3:0]  state_o;
    logic [15:0] inst_cnt_o;
    logic [16:0] outs;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign outs = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o, alu_src_a_o,
                   alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o, mem_to_reg_o, busy_o, err_o};

    multicycle_ctrl #(
        .ACK_TIMEOUT(4),
        .CNT_W      (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .zero_i      (zero_i),
        .mem_ack_i   (mem_ack_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .iord_o      (iord_o),
        .ir_write_o  (ir_write_o),
        .pc_write_o  (pc_write_o),
        .pc_src_o    (pc_src_o),
        .alu_src_a_o (alu_src_a_o),
        .alu_src_b_o (alu_src_b_o),
        .alu_op_o    (alu_op_o),
        .reg_write_o (reg_write_o),
        .reg_dst_o   (reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .state_o     (state_o),
        .inst_cnt_o  (inst_cnt_o)
    );

    // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
    task automatic step(input string tag, input logic ack, input logic st, input logic [5:0] op,
                        input logic z, input logic [3:0] es, input logic [16:0] eo);
        exp_t e;
        mem_ack_i = ack;
        start_i   = st;
        op_i      = op;
        zero_i    = z;
        sb.push_back({es, eo});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert ({state_o, outs} === {e.st, e.o}) else begin
            errors++;
            $error("FAIL %s: state/outs got %h/%h expected %h/%h", tag, state_o, outs, e.st, e.o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp_cnt);
        checks++;
        assert (inst_cnt_o === exp_cnt) else begin
            errors++;
            $error("FAIL %s: inst_cnt got %0d expected %0d", tag, inst_cnt_o, exp_cnt);
        end
    endtask

    task automatic chk_reset(input string tag);
        checks++;
        assert ({state_o, outs} === 21'b0) else begin
            errors++;
            $error("FAIL %s: state/outs got %h/%h expected 0/0", tag, state_o, outs);
        end
        chk_cnt(tag, 16'd0);
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; op_i = R; zero_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;
        rst_i = 1'b1;

        // R-type, ack two cycles after the request
        step("r_idle", 0, 1, R, 0, 4'd0, O_IDLE);
        step("r_f0",   0, 1, R, 0, 4'd1, O_FETCH);
        step("r_f1",   0, 1, R, 0, 4'd1, O_FETCH);
        step("r_f2",   1, 1, R, 0, 4'd1, O_FETCHAK);
        step("r_dec",  0, 1, R, 0, 4'd2, O_DECODE);
        step("r_exec", 0, 1, R, 0, 4'd7, O_EXECR);
        step("r_wb",   0, 0, R, 0, 4'd8, O_WBR);
        chk_cnt("r_cnt", 16'd1);

        // lw, ack in first request cycle each time
        step("lw_idle", 0, 1, LW, 0, 4'd0, O_IDLE);
        step("lw_f",    1, 1, LW, 0, 4'd1, O_FETCHAK);
        step("lw_dec",  0, 1, LW, 0, 4'd2, O_DECODE);
        step("lw_addr", 0, 1, LW, 0, 4'd3, O_ADDR);
        step("lw_rd",   1, 1, LW, 0, 4'd4, O_MEMRD);
        step("lw_wb",   0, 1, LW, 0, 4'd6, O_WBMEM);
        chk_cnt("lw_cnt", 16'd2);

        // beq taken then not taken, back to back
        step("bq1_f",   1, 1, BEQ, 0, 4'd1, O_FETCHAK);
        step("bq1_dec", 0, 1, BEQ, 0, 4'd2, O_DECODE);
        step("bq1_br",  0, 1, BEQ, 1, 4'd11, O_BRT);
        step("bq2_f",   1, 1, BEQ, 0, 4'd1, O_FETCHAK);
        step("bq2_dec", 0, 1, BEQ, 0, 4'd2, O_DECODE);
        step("bq2_br",  0, 0, BEQ, 0, 4'd11, O_BRN);
        chk_cnt("beq_cnt", 16'd4);

        // j then addi
        step("j_idle",  0, 1, J, 0, 4'd0, O_IDLE);
        step("j_f",     1, 1, J, 0, 4'd1, O_FETCHAK);
        step("j_dec",   0, 1, J, 0, 4'd2, O_DECODE);
        step("j_jmp",   0, 1, J, 0, 4'd13, O_JUMP);
        step("ai_f",    1, 1, ADDI, 0, 4'd1, O_FETCHAK);
        step("ai_dec",  0, 1, ADDI, 0, 4'd2, O_DECODE);
        step("ai_exec", 0, 1, ADDI, 0, 4'd9, O_EXECI);
        step("ai_wb",   0, 0, ADDI, 0, 4'd10, O_WBI);
        chk_cnt("ai_cnt", 16'd6);

        // sw: ack in the last allowed fetch cycle, start dropped in ADDR
        step("sw_idle", 0, 1, SW, 0, 4'd0, O_IDLE);
        step("sw_f0",   0, 1, SW, 0, 4'd1, O_FETCH);
        step("sw_f1",   0, 1, SW, 0, 4'd1, O_FETCH);
        step("sw_f2",   0, 1, SW, 0, 4'd1, O_FETCH);
        step("sw_f3",   1, 1, SW, 0, 4'd1, O_FETCHAK);
        step("sw_dec",  0, 1, SW, 0, 4'd2, O_DECODE);
        step("sw_addr", 0, 0, SW, 0, 4'd3, O_ADDR);
        step("sw_wr",   1, 0, SW, 0, 4'd5, O_MEMWR);
        step("sw_end",  0, 0, SW, 0, 4'd0, O_IDLE);
        chk_cnt("sw_cnt", 16'd7);

        // asynchronous reset while waiting in MEM_WR
        step("rs_idle", 0, 1, SW, 0, 4'd0, O_IDLE);
        step("rs_f",    1, 1, SW, 0, 4'd1, O_FETCHAK);
        step("rs_dec",  0, 1, SW, 0, 4'd2, O_DECODE);
        step("rs_addr", 0, 1, SW, 0, 4'd3, O_ADDR);
        step("rs_wr",   0, 1, SW, 0, 4'd5, O_MEMWR);
        #2;
        rst_i = 1'b0;
        #1;
        chk_reset("rst_memwr");
        @(posedge clk); #1;
        chk_reset("rst_hold");
        rst_i = 1'b1;

        // fetch timeout: four request cycles without ack
        step("to_idle", 0, 1, R, 0, 4'd0, O_IDLE);
        step("to_f0",   0, 1, R, 0, 4'd1, O_FETCH);
        step("to_f1",   0, 1, R, 0, 4'd1, O_FETCH);
        step("to_f2",   0, 1, R, 0, 4'd1, O_FETCH);
        step("to_f3",   0, 1, R, 0, 4'd1, O_FETCH);
        step("to_err0", 0, 0, R, 0, 4'd12, O_ERR);
        step("to_err1", 1, 1, R, 0, 4'd12, O_ERR);
        chk_cnt("to_cnt", 16'd0);
        rst_i = 1'b0;
        #1;
        chk_reset("rst_err");
        @(posedge clk); #1;
        rst_i = 1'b1;

        // illegal opcode
        step("il_idle", 0, 1, BAD, 0, 4'd0, O_IDLE);
        step("il_f",    1, 1, BAD, 0, 4'd1, O_FETCHAK);
        step("il_dec",  0, 1, BAD, 0, 4'd2, O_DECODE);
        step("il_err0", 0, 0, BAD, 0, 4'd12, O_ERR);
        step("il_err1", 1, 1, BAD, 0, 4'd12, O_ERR);
        step("il_err2", 0, 0, R, 0, 4'd12, O_ERR);
        chk_cnt("il_cnt", 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
